wb_host_master: RTL
===================

// Module: wb_host_master
// PURPOSE
//   Wishbone classic initiator driving the interconnect M0 port (0x0000_0000-0x0000_3FFF map:
//   SRAM/UART/TRNG/SPI). Converts single read/write commands from a valid/ready command port
//   into one Wishbone cycle, returns data/error on a valid/ready response port.
//   A bus timeout prevents a hung slave from locking the host. Sits between control logic and M0.
// PARAMETERS
//   TIMEOUT   255  cycles STB may stay high without ACK/ERR before forced error; 0 = timeout disabled
// PORTS
//   clk_i         in   1   system clock, all logic on rising edge
//   rst_n         in   1   synchronous active-low reset
//   cmd_valid_i   in   1   command request
//   cmd_ready_o   out  1   command accepted when valid&ready
//   cmd_we_i      in   1   1=write, 0=read
//   cmd_adr_i     in   32  byte address
//   cmd_dat_i     in   32  write data
//   cmd_sel_i     in   4   byte selects
//   rsp_valid_o   out  1   response available
//   rsp_ready_i   in   1   response consumed when valid&ready
//   rsp_dat_o     out  32  read data (0 for writes and errors)
//   rsp_err_o     out  1   1 = slave ERR or timeout
//   m_wb_dat_o    out  32  Wishbone write data
//   m_wb_adr_o    out  32  Wishbone address, bits [1:0] forced 2'b00
//   m_wb_sel_o    out  4   Wishbone byte selects
//   m_wb_we_o     out  1   Wishbone write enable
//   m_wb_cyc_o    out  1   Wishbone cycle
//   m_wb_stb_o    out  1   Wishbone strobe
//   m_wb_dat_i    in   32  Wishbone read data
//   m_wb_ack_i    in   1   Wishbone acknowledge
//   m_wb_err_i    in   1   Wishbone error
// BEHAVIOUR
//   - All outputs registered. Reset (rst_n=0 at edge): state=IDLE, cyc/stb/we=0, adr/dat/sel=0,
//     cmd_ready_o=1 only after reset released, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, timer=0.
//   - FSM IDLE -> BUS -> RESP -> IDLE.
//   - IDLE: cmd_ready_o=1. On cmd_valid_i: latch we/adr/dat/sel, next cycle cyc=stb=1 (state BUS),
//     cmd_ready_o=0. Only one outstanding transaction.
//   - BUS: bus outputs held stable; timer increments each cycle, width $clog2(TIMEOUT+1), saturating.
//     ACK sampled high: cyc=stb=0 next cycle, rsp_dat_o = we ? 0 : m_wb_dat_i, rsp_err_o=0 -> RESP.
//     ERR sampled high (alone or with ACK; ERR wins): rsp_dat_o=0, rsp_err_o=1 -> RESP.
//     TIMEOUT!=0 and timer==TIMEOUT-1 with no ACK/ERR: drop cyc/stb, rsp_err_o=1, rsp_dat_o=0 -> RESP.
//   - Minimum latency: accept at edge N, STB high cycle N+1, zero-wait ACK in N+1 -> rsp_valid_o N+2.
//   - RESP: rsp_valid_o=1, data/err held stable until rsp_ready_i; on handshake rsp_valid_o=0,
//     state IDLE, cmd_ready_o=1 next cycle (no command accept in same cycle as response handshake).
//   - ACK/ERR while not in BUS (late or spurious) ignored, no state change.
//   - Reset mid-transaction: cyc/stb drop at reset edge, pending command and response discarded.
// TESTING
//   1 Write 0x0000_1004 data 0xA5A5_5A5A sel 0xF, ACK after 2 wait cycles -> WB adr 0x0000_1004,
//     we=1, STB 3 cycles, rsp_valid with err=0 dat=0.
//   2 Read 0x0000_2002, zero-wait ACK dat 0x1234_5678 -> m_wb_adr_o 0x0000_2000, rsp_dat_o
//     0x1234_5678 two cycles after accept.
//   3 Read with ACK and ERR in same cycle -> rsp_err_o=1, rsp_dat_o=0.
//   4 TIMEOUT=8, slave never ACKs -> STB high exactly 8 cycles, rsp_err_o=1; later stray ACK ignored.
//   5 rsp_ready_i held low 5 cycles -> rsp_valid/dat stable, cmd_ready_o=0 and new cmd_valid not taken.
//   6 rst_n low during BUS -> next cycle cyc=stb=0, rsp_valid_o=0, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle,
// and the result comes back on a valid/ready response port. A bus timeout guards against hung slaves.
module wb_host_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic [31:0] m_wb_dat_o,
    output logic [31:0] m_wb_adr_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};

    logic [1:0]    state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   wb_adr_q, wb_adr_d;
    logic [31:0]   wb_dat_q, wb_dat_d;
    logic [3:0]    wb_sel_q, wb_sel_d;
    logic          wb_we_q, wb_we_d;
    logic          wb_cyc_q, wb_cyc_d;
    logic [TW-1:0] timer_q, timer_d;

    // Word alignment discards the byte offset of the command address.
    logic [1:0] unused_adr_lsb_s;
    assign unused_adr_lsb_s = cmd_adr_i[1:0];

    // Next-state logic for the single-outstanding transaction FSM.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
        wb_cyc_d    = wb_cyc_q;
        timer_d     = timer_q;
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    wb_adr_d    = {cmd_adr_i[31:2], 2'b00};
                    wb_dat_d    = cmd_dat_i;
                    wb_sel_d    = cmd_sel_i;
                    wb_we_d     = cmd_we_i;
                    wb_cyc_d    = 1'b1;
                    cmd_ready_d = 1'b0;
                    timer_d     = {TW{1'b0}};
                    state_d     = S_BUS;
                end else begin
                    wb_cyc_d = 1'b0;
                end
            end
            S_BUS: begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1'b1);
                // ERR takes priority over a simultaneous ACK.
                if (m_wb_err_i) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'h0000_0000;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else if (m_wb_ack_i) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = wb_we_q ? 32'h0000_0000 : m_wb_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'h0000_0000;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wb_cyc_d = 1'b1;
                end
            end
            S_RESP: begin
                // The accept is deferred one cycle after the response handshake.
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                wb_cyc_d    = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            wb_adr_q    <= 32'h0000_0000;
            wb_dat_q    <= 32'h0000_0000;
            wb_sel_q    <= 4'h0;
            wb_we_q     <= 1'b0;
            wb_cyc_q    <= 1'b0;
            timer_q     <= {TW{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_cyc_q    <= wb_cyc_d;
            timer_q     <= timer_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign m_wb_adr_o  = wb_adr_q;
    assign m_wb_dat_o  = wb_dat_q;
    assign m_wb_sel_o  = wb_sel_q;
    assign m_wb_we_o   = wb_we_q;
    assign m_wb_cyc_o  = wb_cyc_q;
    assign m_wb_stb_o  = wb_cyc_q;

endmodule
